// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared types and constants for the digit-serial adder: FSM
//            state encoding, digit size and the digit-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Bits consumed per clock by the slice adder
    localparam int DIGIT_BITS = 2;

    // Controller states
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // One spare bit above the last digit index so the count never wraps
    function automatic int cnt_width(input int n_digits);
        return $clog2(n_digits) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit2adder.sv
`default_nettype none
// ============================================================================
// Module   : bit2adder
// Purpose  : 2-bit ripple slice: {cout,s1,s0} = {a1,a0} + {b1,b0} + cin.
//            This is the only arithmetic in the serial adder.
// Revision : 1.0 - initial release
// ============================================================================
module bit2adder (
    input  logic a0,
    input  logic a1,
    input  logic b0,
    input  logic b1,
    input  logic cin,
    output logic s0,
    output logic s1,
    output logic cout
);

    logic [2:0] w_total;

    // Three-bit result covers the largest case 3 + 3 + 1
    assign w_total       = {1'b0, a1, a0} + {1'b0, b1, b0} + {2'b00, cin};
    assign {cout, s1, s0} = w_total;

endmodule
`default_nettype wire

// File: rtl/serial_adder2.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder2
// Purpose  : Digit-serial adder. Latches two WIDTH-bit operands and adds them
//            two bits per clock, LSB digit first, through one bit2adder slice
//            and a registered carry. start/busy/done handshake; sum and cout
//            update only on the completing edge.
//            Optional: define SERIAL_ADDER_OVF_EN to add the signed-overflow
//            output ovf.
// Revision : 1.0 - initial release
// ============================================================================
module serial_adder2
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int                 c_num_digits = WIDTH / DIGIT_BITS;
    localparam int                 c_cnt_w      = cnt_width(c_num_digits);
    localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(c_num_digits - 1);

    // Odd or too-small widths cannot be split into whole digits
    generate
        if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
            $error("serial_adder2: WIDTH must be even and >= 2");
        end
    endgenerate

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;
`ifdef SERIAL_ADDER_OVF_EN
    logic               r_a_msb;
    logic               r_b_msb;
`endif

    logic               w_s0;
    logic               w_s1;
    logic               w_cout;
    logic [WIDTH-1:0]   w_acc_next;

    bit2adder u_slice (
        .a0   (r_a[0]),
        .a1   (r_a[1]),
        .b0   (r_b[0]),
        .b1   (r_b[1]),
        .cin  (r_carry),
        .s0   (w_s0),
        .s1   (w_s1),
        .cout (w_cout)
    );

    // New digit enters at the top; after the last digit the first one sits at [1:0]
    assign w_acc_next = WIDTH'({w_s1, w_s0, r_acc} >> DIGIT_BITS);

    // Controller, operand/result shift registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                        busy    <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
                        r_a_msb <= a[WIDTH-1];
                        r_b_msb <= b[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    r_carry <= w_cout;
                    r_acc   <= w_acc_next;
                    r_a     <= r_a >> DIGIT_BITS;
                    r_b     <= r_b >> DIGIT_BITS;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    if (r_cnt == c_last_digit) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= w_acc_next;
                        cout    <= w_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf     <= (r_a_msb == r_b_msb) &&
                                   (w_acc_next[WIDTH-1] != r_a_msb);
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder2.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder2
// Purpose  : Self-checking bench for serial_adder2 at WIDTH=8. Expected
//            results come from plain integer addition of the operands that
//            were present on the accepting edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder2;

    localparam int W = 8;
    localparam int N = W / 2;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: last completed result
    logic [W-1:0] m_sum;
    logic         m_cout;
    logic         m_ovf;

    serial_adder2 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_sum"},  32'(sum),  32'(m_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"},  32'(ovf),  32'(m_ovf));
`endif
    endtask

    // One operation; called away from a rising edge. With hold=1, start stays
    // high and operands are scrambled every cycle while the DUT is busy.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input bit hold);
        logic [W:0] full;
        int         ssum;
        start = 1'b1;
        a     = oa;
        b     = ob;
        cin   = oc;
        @(posedge clk); #1;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        full = {1'b0, oa} + {1'b0, ob} + {{W{1'b0}}, oc};
        ssum = int'($signed(oa)) + int'($signed(ob)) + int'(oc);
        if (!hold) start = 1'b0;
        for (int k = 1; k <= N; k++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            @(posedge clk); #1;
            if (k < N) begin
                chk("run_busy", 32'(busy), 32'd1);
                chk("run_done", 32'(done), 32'd0);
                chk_outputs("run_held");
            end else begin
                m_sum  = full[W-1:0];
                m_cout = full[W];
                m_ovf  = (ssum > 127) || (ssum < -128);
                chk("fin_done", 32'(done), 32'd1);
                chk("fin_busy", 32'(busy), 32'd0);
                chk_outputs("fin");
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk("idle_done", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
            chk_outputs("idle_hold");
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        m_sum  = '0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk_outputs("rst");
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Directed operations
        run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0);
        idle_cycles(1);
        run_op(8'h7F, 8'h00, 1'b1, 1'b0);
        idle_cycles(1);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        idle_cycles(3);

        // Asynchronous reset after two digits of a run
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'hA5;
        cin   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst_n = 1'b0;
        #1;
        m_sum  = '0;
        m_cout = 1'b0;
        m_ovf  = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk_outputs("midrst");
        @(negedge clk) rst_n = 1'b1;
        idle_cycles(1);
        run_op(8'h12, 8'h34, 1'b1, 1'b0);
        idle_cycles(1);

        // start held high; second op accepted on the done cycle
        run_op(8'h11, 8'h22, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0);
        idle_cycles(1);

        // Random operations, some back-to-back
        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycles(1);
        end
        idle_cycles(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
